// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging the I-cache refill port and the data-memory port onto one
// shared memory bus, with registered bus outputs and a bus-timeout counter.
module mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_IC_DataReq,
    input  logic [XLEN-1:0] i_IC_Addr,
    output logic [XLEN-1:0] o_IC_Data,
    output logic            o_IC_MemReady,
    input  logic            i_DM_MemRead,
    input  logic            i_DM_Wen,
    input  logic [XLEN-1:0] i_DM_Addr,
    input  logic [XLEN-1:0] i_DM_Wd,
    input  logic [2:0]      i_DM_f3,
    output logic [XLEN-1:0] o_DM_ReadData,
    output logic            o_DM_data_ready,
    output logic            o_MEM_req,
    output logic            o_MEM_we,
    output logic [XLEN-1:0] o_MEM_addr,
    output logic [XLEN-1:0] o_MEM_wdata,
    output logic [2:0]      o_MEM_f3,
    input  logic            i_MEM_ready,
    input  logic [XLEN-1:0] i_MEM_rdata,
    output logic            o_bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             last_dm;   // 1 when the data side owns / last owned the bus
    logic [CNT_W-1:0] cnt;
    logic             dm_req;
    logic             grant_dm;

    assign dm_req   = i_DM_MemRead | i_DM_Wen;
    assign grant_dm = dm_req && (!i_IC_DataReq || !last_dm);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state           <= IDLE;
            last_dm         <= 1'b0;
            cnt             <= '0;
            o_IC_Data       <= '0;
            o_IC_MemReady   <= 1'b0;
            o_DM_ReadData   <= '0;
            o_DM_data_ready <= 1'b0;
            o_MEM_req       <= 1'b0;
            o_MEM_we        <= 1'b0;
            o_MEM_addr      <= '0;
            o_MEM_wdata     <= '0;
            o_MEM_f3        <= '0;
            o_bus_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_IC_DataReq || dm_req) begin
                        state     <= BUSY;
                        o_MEM_req <= 1'b1;
                        cnt       <= '0;
                        last_dm   <= grant_dm;
                        if (grant_dm) begin
                            o_MEM_addr  <= i_DM_Addr;
                            o_MEM_wdata <= i_DM_Wd;
                            o_MEM_f3    <= i_DM_f3;
                            o_MEM_we    <= i_DM_Wen;
                        end else begin
                            o_MEM_addr  <= i_IC_Addr;
                            o_MEM_wdata <= '0;
                            o_MEM_f3    <= 3'b010;
                            o_MEM_we    <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (i_MEM_ready || cnt == CNT_LAST) begin
                        // Timeout returns zero data and flags the error alongside the pulse.
                        state     <= RESP;
                        o_MEM_req <= 1'b0;
                        o_bus_err <= !i_MEM_ready;
                        if (last_dm) begin
                            o_DM_ReadData   <= i_MEM_ready ? i_MEM_rdata : '0;
                            o_DM_data_ready <= 1'b1;
                        end else begin
                            o_IC_Data     <= i_MEM_ready ? i_MEM_rdata : '0;
                            o_IC_MemReady <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state           <= IDLE;
                    o_IC_MemReady   <= 1'b0;
                    o_DM_data_ready <= 1'b0;
                    o_bus_err       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of grants,
// bus fields, returned data, timeout and ready pulses.
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam int TO   = 4;
    localparam int CW   = 3;

    logic            i_clk;
    logic            i_rst;
    logic            i_IC_DataReq;
    logic [XLEN-1:0] i_IC_Addr;
    logic [XLEN-1:0] o_IC_Data;
    logic            o_IC_MemReady;
    logic            i_DM_MemRead;
    logic            i_DM_Wen;
    logic [XLEN-1:0] i_DM_Addr;
    logic [XLEN-1:0] i_DM_Wd;
    logic [2:0]      i_DM_f3;
    logic [XLEN-1:0] o_DM_ReadData;
    logic            o_DM_data_ready;
    logic            o_MEM_req;
    logic            o_MEM_we;
    logic [XLEN-1:0] o_MEM_addr;
    logic [XLEN-1:0] o_MEM_wdata;
    logic [2:0]      o_MEM_f3;
    logic            i_MEM_ready;
    logic [XLEN-1:0] i_MEM_rdata;
    logic            o_bus_err;

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_IC_DataReq(i_IC_DataReq), .i_IC_Addr(i_IC_Addr),
        .o_IC_Data(o_IC_Data), .o_IC_MemReady(o_IC_MemReady),
        .i_DM_MemRead(i_DM_MemRead), .i_DM_Wen(i_DM_Wen), .i_DM_Addr(i_DM_Addr),
        .i_DM_Wd(i_DM_Wd), .i_DM_f3(i_DM_f3),
        .o_DM_ReadData(o_DM_ReadData), .o_DM_data_ready(o_DM_data_ready),
        .o_MEM_req(o_MEM_req), .o_MEM_we(o_MEM_we), .o_MEM_addr(o_MEM_addr),
        .o_MEM_wdata(o_MEM_wdata), .o_MEM_f3(o_MEM_f3),
        .i_MEM_ready(i_MEM_ready), .i_MEM_rdata(i_MEM_rdata), .o_bus_err(o_bus_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: who was served last and what each side's data output should hold.
    bit              m_last_dm;
    logic [XLEN-1:0] m_ic_data;
    logic [XLEN-1:0] m_dm_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {o_IC_MemReady, o_DM_data_ready, o_MEM_req, o_MEM_we,
                              o_MEM_f3, o_bus_err}, '0);
        check({tag, "_addr"}, o_MEM_addr, '0);
        check({tag, "_wdata"}, o_MEM_wdata, '0);
        check({tag, "_icdata"}, o_IC_Data, '0);
        check({tag, "_dmdata"}, o_DM_ReadData, '0);
    endtask

    task automatic randomize_fields;
        i_IC_Addr = $urandom;
        i_DM_Addr = $urandom;
        i_DM_Wd   = $urandom;
        i_DM_f3   = 3'($urandom_range(0, 7));
    endtask

    // force_d < 0: random bus delay; force_d == TO: bus never answers (timeout).
    task automatic run_trial(input bit force_both, input int force_d);
        bit              ic, dm, wen, rd, g_dm, tmo;
        int              d, nwait;
        logic [1:0]      r;
        logic [XLEN-1:0] e_addr, e_wd, rdata;
        logic            e_we;
        logic [2:0]      e_f3;

        ic = force_both | 1'($urandom_range(0, 1));
        dm = force_both | 1'($urandom_range(0, 1));
        r  = 2'($urandom_range(1, 3));
        wen = dm & r[1];
        rd  = dm & r[0];
        i_IC_DataReq = ic;
        i_DM_Wen     = wen;
        i_DM_MemRead = rd;
        randomize_fields();
        i_MEM_ready = 1'($urandom_range(0, 1));
        i_MEM_rdata = $urandom;

        if (!ic && !dm) begin
            tick();
            i_MEM_ready = 1'b0;
            check("idle_req", o_MEM_req, 1'b0);
            check("idle_pulses", {o_IC_MemReady, o_DM_data_ready, o_bus_err}, '0);
            return;
        end

        g_dm   = dm && (!ic || !m_last_dm);
        e_addr = g_dm ? i_DM_Addr : i_IC_Addr;
        e_we   = g_dm ? wen : 1'b0;
        e_f3   = g_dm ? i_DM_f3 : 3'b010;
        e_wd   = i_DM_Wd;
        m_last_dm = g_dm;

        tick();
        i_MEM_ready = 1'b0;
        check("grant_req", o_MEM_req, 1'b1);
        check("grant_addr", o_MEM_addr, e_addr);
        check("grant_we", o_MEM_we, e_we);
        check("grant_f3", o_MEM_f3, e_f3);
        if (g_dm) check("grant_wdata", o_MEM_wdata, e_wd);
        check("grant_pulses", {o_IC_MemReady, o_DM_data_ready, o_bus_err}, '0);

        // Inputs may change or drop mid-transfer; the bus fields must not.
        randomize_fields();
        if ($urandom_range(0, 3) == 0) begin
            i_IC_DataReq = 1'b0;
            i_DM_Wen     = 1'b0;
            i_DM_MemRead = 1'b0;
        end

        d     = (force_d >= 0) ? force_d : $urandom_range(0, TO);
        tmo   = (d >= TO);
        nwait = tmo ? TO - 1 : d;
        for (int k = 0; k < nwait; k++) begin
            tick();
            check("busy_req", o_MEM_req, 1'b1);
            check("busy_addr", o_MEM_addr, e_addr);
            check("busy_pulses", {o_IC_MemReady, o_DM_data_ready}, '0);
        end
        rdata = $urandom;
        if (!tmo) begin
            i_MEM_ready = 1'b1;
            i_MEM_rdata = rdata;
        end
        tick();
        i_MEM_ready = 1'b0;

        if (g_dm) m_dm_data = tmo ? '0 : rdata;
        else      m_ic_data = tmo ? '0 : rdata;
        check("resp_ic_ready", o_IC_MemReady, !g_dm);
        check("resp_dm_ready", o_DM_data_ready, g_dm);
        check("resp_err", o_bus_err, tmo);
        check("resp_req", o_MEM_req, 1'b0);
        check("resp_ic_data", o_IC_Data, m_ic_data);
        check("resp_dm_data", o_DM_ReadData, m_dm_data);

        // Stray ready and held requests during the response cycle must be ignored.
        i_MEM_ready = 1'($urandom_range(0, 1));
        i_IC_DataReq = 1'($urandom_range(0, 1));
        i_DM_MemRead = 1'($urandom_range(0, 1));
        tick();
        i_MEM_ready = 1'b0;
        check("post_pulses", {o_IC_MemReady, o_DM_data_ready, o_bus_err}, '0);
        check("post_req", o_MEM_req, 1'b0);
        check("post_ic_data", o_IC_Data, m_ic_data);
        check("post_dm_data", o_DM_ReadData, m_dm_data);
    endtask

    task automatic model_reset;
        m_last_dm = 1'b0;
        m_ic_data = '0;
        m_dm_data = '0;
    endtask

    initial begin
        i_rst = 1'b0;
        i_IC_DataReq = 1'b0; i_DM_MemRead = 1'b0; i_DM_Wen = 1'b0;
        i_IC_Addr = '0; i_DM_Addr = '0; i_DM_Wd = '0; i_DM_f3 = '0;
        i_MEM_ready = 1'b0; i_MEM_rdata = '0;
        model_reset();
        tick();
        tick();
        check_all_zero("reset");
        i_rst = 1'b1;

        run_trial(1'b1, 2);    // both after reset: data side first
        run_trial(1'b1, 0);    // both again: I-cache, zero-wait bus
        run_trial(1'b1, TO);   // both again: data side, timeout
        for (int i = 0; i < 200; i++) run_trial(1'b0, -1);

        // Asynchronous reset in the middle of a transfer.
        i_IC_DataReq = 1'b1; i_DM_MemRead = 1'b1; i_DM_Wen = 1'b0;
        tick();
        tick();
        check("pre_rst_req", o_MEM_req, 1'b1);
        #2;
        i_rst = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        check_all_zero("midrst_hold");
        i_rst = 1'b1;
        model_reset();
        run_trial(1'b1, 1);    // restart from scratch: data side wins again
        for (int i = 0; i < 60; i++) run_trial(1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
